draw_banner_text: RTL and testbench

DRAW_BANNER_TEXT -- requirements
Module: draw_banner_text

---
 rtl/vga_pkg.sv | 26 ++
 rtl/banner_anim.sv | 69 ++++++
 rtl/delay.sv | 31 +++
 rtl/draw_banner_text.sv | 141 ++++++++++++++
 tb/tb_draw_banner_text.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA project package: glyph geometry, colour constants and the
// bundle of raster signals that travels down every drawing pipeline.
package vga_pkg;

  localparam int CHAR_W = 8;
  localparam int CHAR_H = 16;

  localparam logic [11:0] RGB_BLACK = 12'h000;
  localparam logic [11:0] RGB_WHITE = 12'hfff;

  typedef struct packed {
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        hsync;
    logic        hblnk;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;

  // Origin that centres an object of `size` px inside the window [lo, hi).
  function automatic int centre(input int lo, input int hi, input int size);
    return lo + ((hi - lo - size) >>> 1);
  endfunction

endpackage

// File: rtl/banner_anim.sv
// Frame-rate banner state: latched message, slide-in offset and blink phase.
// Everything here moves only on the frame event.
module banner_anim #(
  parameter int MSG_SEL_WIDTH = 2,
  parameter int BLINK_FRAMES  = 30,
  parameter int SLIDE_OFFSET  = 64,
  parameter int SLIDE_STEP    = 4,
  parameter int SLIDE_W       = (SLIDE_OFFSET > 0) ? $clog2(SLIDE_OFFSET + 1) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_evt,
  input  logic [MSG_SEL_WIDTH-1:0] msg_sel,
  input  logic                     blink_en,
  output logic [MSG_SEL_WIDTH-1:0] msg_q,
  output logic [SLIDE_W-1:0]       slide_off,
  output logic                     blink_on
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [MSG_SEL_WIDTH-1:0] msg_d;
  logic [SLIDE_W-1:0]       slide_q, slide_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     blink_q, blink_d;

  // NOTE: defaults first so every path assigns every signal and no latch appears.
  always_comb begin
    msg_d   = msg_q;
    slide_d = slide_q;
    cnt_d   = cnt_q;
    blink_d = blink_q;
    if (frame_evt) begin
      msg_d = msg_sel;
      if (msg_sel != '0 && msg_sel != msg_q)      slide_d = SLIDE_W'(SLIDE_OFFSET);
      else if (slide_q > SLIDE_W'(SLIDE_STEP))   slide_d = slide_q - SLIDE_W'(SLIDE_STEP);
      else                                       slide_d = '0;
      // Blink stays parked (text shown) until the slide has fully settled.
      if (!blink_en || slide_q != '0 || slide_d != '0) begin
        cnt_d   = '0;
        blink_d = 1'b1;
      end else if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        cnt_d   = '0;
        blink_d = !blink_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: non-blocking so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      msg_q   <= '0;
      slide_q <= '0;
      cnt_q   <= '0;
      blink_q <= 1'b1;
    end else begin
      msg_q   <= msg_d;
      slide_q <= slide_d;
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
    end
  end

  assign slide_off = slide_q;
  assign blink_on  = blink_q;

endmodule

// File: rtl/delay.sv
// Generic clocked delay line: dout is din delayed by CLK_DEL cycles.
module delay #(
  parameter int WIDTH   = 8,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_q [CLK_DEL];
  logic [WIDTH-1:0] pipe_d [CLK_DEL];

  always_comb begin
    pipe_d[0] = din;
    for (int i = 1; i < CLK_DEL; i++) pipe_d[i] = pipe_q[i-1];
  end

  // NOTE: every stage is cleared so no stale pixels drain out after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CLK_DEL; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign dout = pipe_q[CLK_DEL-1];

endmodule

// File: rtl/draw_banner_text.sv
// Centred text banner overlay: slides in on message change, optional blink,
// 3-cycle pipeline around an external char+font ROM chain.
module draw_banner_text import vga_pkg::*; #(
  parameter int          X_ADDR_WIDTH  = 4,
  parameter int          Y_ADDR_WIDTH  = 1,
  parameter int          SCALE_COEFF   = 0,
  parameter int          X_CHAR_COUNT  = 16,
  parameter int          Y_CHAR_COUNT  = 2,
  parameter int          MSG_SEL_WIDTH = 2,
  parameter int          X_MIN         = 0,
  parameter int          X_MAX         = 0,
  parameter int          Y_MIN         = 0,
  parameter int          Y_MAX         = 0,
  parameter logic [11:0] COLOR         = RGB_WHITE,
  parameter logic [11:0] BG_COLOR      = RGB_BLACK,
  parameter bit          BG_EN         = 1'b0,
  parameter int          BLINK_FRAMES  = 30,
  parameter int          SLIDE_OFFSET  = 64,
  parameter int          SLIDE_STEP    = 4
) (
  input  logic                                          i_pclk,
  input  logic                                          i_rst,
  input  logic [11:0]                                   i_hcount,
  input  logic [11:0]                                   i_vcount,
  input  logic                                          i_hsync,
  input  logic                                          i_hblnk,
  input  logic                                          i_vsync,
  input  logic                                          i_vblnk,
  input  logic [11:0]                                   i_rgb,
  input  logic [MSG_SEL_WIDTH-1:0]                      i_msg_sel,
  input  logic                                          i_blink_en,
  input  logic [7:0]                                    i_rom_word,
  output logic [11:0]                                   o_hcount,
  output logic [11:0]                                   o_vcount,
  output logic                                          o_hsync,
  output logic                                          o_hblnk,
  output logic                                          o_vsync,
  output logic                                          o_vblnk,
  output logic [11:0]                                   o_rgb,
  output logic [MSG_SEL_WIDTH+Y_ADDR_WIDTH+X_ADDR_WIDTH-1:0] o_char_addr,
  output logic [3:0]                                    o_char_line
);

  localparam int W         = X_CHAR_COUNT * (CHAR_W << SCALE_COEFF);
  localparam int H         = Y_CHAR_COUNT * (CHAR_H << SCALE_COEFF);
  localparam int XPOS      = centre(X_MIN, X_MAX, W);
  localparam int YPOS_BASE = centre(Y_MIN, Y_MAX, H);
  localparam int SLIDE_W   = (SLIDE_OFFSET > 0) ? $clog2(SLIDE_OFFSET + 1) : 1;
  localparam int ADDR_W    = MSG_SEL_WIDTH + Y_ADDR_WIDTH + X_ADDR_WIDTH;
  localparam int RW        = 14;

  typedef struct packed {
    logic       visible;
    logic [3:0] line;
    logic [2:0] bit_idx;
    vga_t       vga;
  } px_t;

  logic                     vblnk_prev_q, vblnk_prev_d;
  logic                     frame_evt;
  logic [MSG_SEL_WIDTH-1:0] msg_q;
  logic [SLIDE_W-1:0]       slide_off;
  logic                     blink_on;
  logic signed [RW-1:0]     ypos, rel_h, rel_v;
  logic                     in_box;
  logic [ADDR_W-1:0]        char_addr;
  px_t                      px0, px2;
  vga_t                     out_q, out_d;

  assign frame_evt = i_vblnk & ~vblnk_prev_q;

  banner_anim #(
    .MSG_SEL_WIDTH (MSG_SEL_WIDTH),
    .BLINK_FRAMES  (BLINK_FRAMES),
    .SLIDE_OFFSET  (SLIDE_OFFSET),
    .SLIDE_STEP    (SLIDE_STEP),
    .SLIDE_W       (SLIDE_W)
  ) u_anim (
    .clk       (i_pclk),
    .rst       (i_rst),
    .frame_evt (frame_evt),
    .msg_sel   (i_msg_sel),
    .blink_en  (i_blink_en),
    .msg_q     (msg_q),
    .slide_off (slide_off),
    .blink_on  (blink_on)
  );

  // Signed coordinates so pixels left of / above the box never alias inside.
  always_comb begin
    vblnk_prev_d = i_vblnk;
    ypos   = RW'(YPOS_BASE) - RW'(slide_off);
    rel_h  = RW'(i_hcount) - RW'(XPOS);
    rel_v  = RW'(i_vcount) - ypos;
    in_box = !rel_h[RW-1] && (rel_h < RW'(W)) && !rel_v[RW-1] && (rel_v < RW'(H));
    char_addr = {msg_q - MSG_SEL_WIDTH'(1),
                 rel_v[Y_ADDR_WIDTH+3+SCALE_COEFF : 4+SCALE_COEFF],
                 rel_h[X_ADDR_WIDTH+2+SCALE_COEFF : 3+SCALE_COEFF]};
    px0.visible = (msg_q != '0) && blink_on && in_box;
    px0.line    = rel_v[3+SCALE_COEFF : SCALE_COEFF];
    px0.bit_idx = rel_h[2+SCALE_COEFF : SCALE_COEFF];
    px0.vga     = '{i_hcount, i_vcount, i_hsync, i_hblnk, i_vsync, i_vblnk, i_rgb};
  end

  delay #(.WIDTH(ADDR_W), .CLK_DEL(1)) u_addr_dly (
    .clk (i_pclk), .rst (i_rst), .din (char_addr), .dout (o_char_addr)
  );

  delay #(.WIDTH($bits(px_t)), .CLK_DEL(2)) u_px_dly (
    .clk (i_pclk), .rst (i_rst), .din (px0), .dout (px2)
  );

  assign o_char_line = px2.line;

  // Font row arrives alongside o_char_line; colour is resolved here.
  always_comb begin
    out_d = px2.vga;
    if (px2.vga.hblnk || px2.vga.vblnk)                      out_d.rgb = RGB_BLACK;
    else if (px2.visible && i_rom_word[3'd7 - px2.bit_idx])  out_d.rgb = COLOR;
    else if (px2.visible && BG_EN)                           out_d.rgb = BG_COLOR;
  end

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      vblnk_prev_q <= 1'b0;
      out_q        <= '0;
    end else begin
      vblnk_prev_q <= vblnk_prev_d;
      out_q        <= out_d;
    end
  end

  assign o_hcount = out_q.hcount;
  assign o_vcount = out_q.vcount;
  assign o_hsync  = out_q.hsync;
  assign o_hblnk  = out_q.hblnk;
  assign o_vsync  = out_q.vsync;
  assign o_vblnk  = out_q.vblnk;
  assign o_rgb    = out_q.rgb;

endmodule

// File: tb/tb_draw_banner_text.sv
// Directed bench for draw_banner_text: a 2x1-character box centred in a
// 24x160 window (XPOS=4, YPOS_BASE=72), frames driven as single vblnk pulses.
module tb_draw_banner_text;

  localparam logic [11:0] COLOR    = 12'hfff;
  localparam logic [11:0] BG_COLOR = 12'h00f;
  localparam int XPOS      = 4;
  localparam int YPOS_BASE = 72;

  logic        i_pclk = 1'b0;
  logic        i_rst;
  logic [11:0] i_hcount, i_vcount, i_rgb;
  logic        i_hsync, i_hblnk, i_vsync, i_vblnk;
  logic [1:0]  i_msg_sel;
  logic        i_blink_en;
  logic [7:0]  i_rom_word;
  logic [11:0] o_hcount, o_vcount, o_rgb;
  logic        o_hsync, o_hblnk, o_vsync, o_vblnk;
  logic [3:0]  o_char_addr;
  logic [3:0]  o_char_line;

  int n_vec = 0;
  int n_err = 0;

  always #5 i_pclk = ~i_pclk;

  draw_banner_text #(
    .X_ADDR_WIDTH (1), .Y_ADDR_WIDTH (1), .SCALE_COEFF (0),
    .X_CHAR_COUNT (2), .Y_CHAR_COUNT (1), .MSG_SEL_WIDTH (2),
    .X_MIN (0), .X_MAX (24), .Y_MIN (0), .Y_MAX (160),
    .COLOR (COLOR), .BG_COLOR (BG_COLOR), .BG_EN (1'b1),
    .BLINK_FRAMES (2), .SLIDE_OFFSET (64), .SLIDE_STEP (4)
  ) dut (
    .i_pclk (i_pclk), .i_rst (i_rst),
    .i_hcount (i_hcount), .i_vcount (i_vcount),
    .i_hsync (i_hsync), .i_hblnk (i_hblnk), .i_vsync (i_vsync), .i_vblnk (i_vblnk),
    .i_rgb (i_rgb), .i_msg_sel (i_msg_sel), .i_blink_en (i_blink_en),
    .i_rom_word (i_rom_word),
    .o_hcount (o_hcount), .o_vcount (o_vcount),
    .o_hsync (o_hsync), .o_hblnk (o_hblnk), .o_vsync (o_vsync), .o_vblnk (o_vblnk),
    .o_rgb (o_rgb), .o_char_addr (o_char_addr), .o_char_line (o_char_line)
  );

  typedef struct {
    int          h;
    int          v;
    logic [11:0] rgb;
    logic [7:0]  rom;
    logic        hb;
    logic [11:0] exp_rgb;
    logic [3:0]  exp_addr;
    logic [3:0]  exp_line;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string name);
    check(name, {o_hcount, o_vcount, o_hsync, o_hblnk, o_vsync, o_vblnk,
                 o_rgb, o_char_addr, o_char_line}, 64'd0);
  endtask

  // Hold one pixel for three clocks, then compare o_rgb at the falling edge.
  task automatic probe(input string name, input int h, input int v, input logic [11:0] rgb,
                       input logic [7:0] rom, input logic hb, input logic [11:0] exp_rgb);
    @(negedge i_pclk);
    i_hcount = 12'(h);  i_vcount = 12'(v);
    i_hsync = 1'b0;  i_vsync = 1'b0;  i_hblnk = hb;  i_vblnk = 1'b0;
    i_rgb = rgb;  i_rom_word = rom;
    repeat (3) @(negedge i_pclk);
    check(name, 64'(o_rgb), 64'(exp_rgb));
  endtask

  task automatic frame();
    @(negedge i_pclk);
    i_vblnk = 1'b1;
    @(negedge i_pclk);
    i_vblnk = 1'b0;
  endtask

  initial begin
    vec_t tbl[12];
    logic [39:0] pipe_exp[20];
    int yp;

    // Static-state vectors: msg 2, slide done, blink off; box at h 4..19, v 72..87.
    tbl[0]  = '{4,  72, 12'h123, 8'h81, 1'b0, COLOR,    4'h4, 4'h0};
    tbl[1]  = '{5,  72, 12'h123, 8'h81, 1'b0, BG_COLOR, 4'h4, 4'h0};
    tbl[2]  = '{11, 72, 12'h123, 8'h81, 1'b0, COLOR,    4'h4, 4'h0};
    tbl[3]  = '{10, 72, 12'h123, 8'h81, 1'b0, BG_COLOR, 4'h4, 4'h0};
    tbl[4]  = '{12, 75, 12'h123, 8'h81, 1'b0, COLOR,    4'h5, 4'h3};
    tbl[5]  = '{19, 87, 12'h123, 8'h01, 1'b0, COLOR,    4'h5, 4'hf};
    tbl[6]  = '{3,  72, 12'h123, 8'hff, 1'b0, 12'h123,  4'h5, 4'h0};
    tbl[7]  = '{20, 72, 12'h123, 8'hff, 1'b0, 12'h123,  4'h4, 4'h0};
    tbl[8]  = '{4,  88, 12'h123, 8'hff, 1'b0, 12'h123,  4'h6, 4'h0};
    tbl[9]  = '{4,  71, 12'h123, 8'hff, 1'b0, 12'h123,  4'h6, 4'hf};
    tbl[10] = '{4,  72, 12'h123, 8'hff, 1'b1, 12'h000,  4'h4, 4'h0};
    tbl[11] = '{8,  80, 12'h123, 8'h00, 1'b0, BG_COLOR, 4'h4, 4'h8};

    // Reset with busy inputs: everything must read zero.
    i_rst = 1'b1;  i_hcount = 12'd5;  i_vcount = 12'd72;  i_rgb = 12'hfff;
    i_hsync = 1'b1;  i_hblnk = 1'b0;  i_vsync = 1'b1;  i_vblnk = 1'b0;
    i_msg_sel = 2'd2;  i_blink_en = 1'b0;  i_rom_word = 8'hff;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_pclk);
      check_zero("reset_init");
      i_vblnk = ~i_vblnk;
    end
    @(negedge i_pclk);
    i_rst = 1'b0;  i_vblnk = 1'b0;  i_msg_sel = 2'd0;

    // Pass-through pipeline with changing timing, exactly 3 cycles late.
    for (int k = 0; k < 20; k++) begin
      logic hb, vb;
      hb = (k % 5 == 4);
      vb = (k == 10 || k == 11);
      pipe_exp[k] = {12'(100 + k), 12'(200 + 7 * k), k[0], hb, k[1], vb,
                     (hb || vb) ? 12'h000 : 12'h0a5};
    end
    for (int k = 0; k < 23; k++) begin
      @(negedge i_pclk);
      if (k >= 3)
        check($sformatf("pipe%0d", k - 3),
              64'({o_hcount, o_vcount, o_hsync, o_hblnk, o_vsync, o_vblnk, o_rgb}),
              64'(pipe_exp[k - 3]));
      if (k < 20)
        {i_hcount, i_vcount, i_hsync, i_hblnk, i_vsync, i_vblnk, i_rgb} = pipe_exp[k][39:12] == 28'd0 ?
          40'd0 : {pipe_exp[k][39:12], 12'h0a5};
    end

    // Message changed mid-frame: still hidden until the next frame event.
    i_msg_sel = 2'd2;
    probe("latch_hold", XPOS, YPOS_BASE, 12'h0a5, 8'hff, 1'b0, 12'h0a5);
    frame();
    probe("latch_glyph", XPOS, YPOS_BASE - 64, 12'h0a5, 8'h80, 1'b0, COLOR);
    check("latch_addr", 64'(o_char_addr), 64'h4);
    probe("latch_bg", XPOS + 1, YPOS_BASE - 64, 12'h0a5, 8'h80, 1'b0, BG_COLOR);

    // Slide: top line at YPOS_BASE-64, -60, ... settling at YPOS_BASE.
    for (int k = 1; k <= 18; k++) begin
      yp = YPOS_BASE - ((64 - 4 * (k - 1)) > 0 ? (64 - 4 * (k - 1)) : 0);
      probe($sformatf("slide%0d_top", k), XPOS, yp, 12'h0a5, 8'hff, 1'b0, COLOR);
      probe($sformatf("slide%0d_above", k), XPOS, yp - 1, 12'h0a5, 8'hff, 1'b0, 12'h0a5);
      if (k < 18) frame();
    end

    for (int i = 0; i < 12; i++) begin
      probe($sformatf("vec%0d_rgb", i), tbl[i].h, tbl[i].v, tbl[i].rgb, tbl[i].rom,
            tbl[i].hb, tbl[i].exp_rgb);
      check($sformatf("vec%0d_addr", i), 64'(o_char_addr), 64'(tbl[i].exp_addr));
      check($sformatf("vec%0d_line", i), 64'(o_char_line), 64'(tbl[i].exp_line));
    end

    // Blink with BLINK_FRAMES=2: two frames shown, two hidden.
    @(negedge i_pclk);
    i_blink_en = 1'b1;
    for (int j = 0; j < 8; j++) begin
      frame();
      probe($sformatf("blink%0d", j), XPOS, YPOS_BASE, 12'h123, 8'hff, 1'b0,
            (((j + 1) % 4) < 2) ? COLOR : 12'h123);
    end
    @(negedge i_pclk);
    i_blink_en = 1'b0;
    for (int j = 0; j < 3; j++) begin
      frame();
      probe($sformatf("noblink%0d", j), XPOS, YPOS_BASE, 12'h123, 8'hff, 1'b0, COLOR);
    end

    // New message, reset at slide frame 5, then a full slide from 64 again.
    i_msg_sel = 2'd1;
    for (int j = 0; j < 5; j++) frame();
    probe("midslide", XPOS, YPOS_BASE - 48, 12'h0a5, 8'hff, 1'b0, COLOR);
    check("midslide_addr", 64'(o_char_addr), 64'h0);
    @(negedge i_pclk);
    i_rst = 1'b1;  i_vblnk = 1'b1;  i_rgb = 12'hfff;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_pclk);
      check_zero("reset_mid");
    end
    @(negedge i_pclk);
    i_rst = 1'b0;  i_vblnk = 1'b0;
    probe("post_rst_mid", XPOS, YPOS_BASE - 48, 12'h0a5, 8'hff, 1'b0, 12'h0a5);
    probe("post_rst_base", XPOS, YPOS_BASE, 12'h0a5, 8'hff, 1'b0, 12'h0a5);
    frame();
    probe("restart_top", XPOS, YPOS_BASE - 64, 12'h0a5, 8'hff, 1'b0, COLOR);
    probe("restart_above", XPOS, YPOS_BASE - 65, 12'h0a5, 8'hff, 1'b0, 12'h0a5);
    frame();
    probe("restart2_top", XPOS, YPOS_BASE - 60, 12'h0a5, 8'hff, 1'b0, COLOR);
    probe("restart2_above", XPOS, YPOS_BASE - 61, 12'h0a5, 8'hff, 1'b0, 12'h0a5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
